// File: rtl/corr_pkg.sv
// Shared types, defaults and width helpers for the correlation sequencer.
package corr_pkg;

    localparam int unsigned N_DEF     = 32;
    localparam int unsigned LAGS_DEF  = 32;
    localparam int unsigned DECIM_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_CORR,
        ST_REPORT
    } state_e;

    function automatic int unsigned peak_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned lag_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/corr_window_buf.sv
// Decimated sample strobe and N-bit capture window; first sample lands in w[0].
module corr_window_buf
    import corr_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned DECIM = DECIM_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         sig,
    output logic [N-1:0] w,
    output logic         full
);
    localparam int unsigned IW = lag_w(N);
    localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [DW-1:0] dec_q;
    logic [IW-1:0] idx_q;
    logic [N-1:0]  w_q;
    logic          dec_zero;
    logic          dec_wrap;

    assign dec_zero = (dec_q == '0);
    assign dec_wrap = (dec_q == DW'(DECIM - 1));
    // Window completes only once the last strobe period has elapsed, so capture spans N*DECIM cycles.
    assign full     = en && dec_wrap && (idx_q == IW'(N - 1));
    assign w        = w_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            dec_q <= '0;
            idx_q <= '0;
            w_q   <= '0;
        end else if (en) begin
            if (dec_zero) begin
                w_q[idx_q] <= sig;
            end
            if (dec_wrap) begin
                dec_q <= '0;
                idx_q <= idx_q + 1'b1;
            end else begin
                dec_q <= dec_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/corr_sequencer.sv
// Time-shared 1-bit correlator: capture a window, score LAGS circular lags, report best.
module corr_sequencer
    import corr_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned LAGS  = LAGS_DEF,
    parameter int unsigned DECIM = DECIM_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sig,
    input  logic                 start,
    input  logic                 auto,
    input  logic [N-1:0]         ref_code,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [peak_w(N)-1:0] res_peak,
    output logic [lag_w(N)-1:0]  res_lag
);
    localparam int unsigned PW = peak_w(N);
    localparam int unsigned IW = lag_w(N);

    state_e        state_q, state_d;
    logic [N-1:0]  ref_q, ref_d;
    logic [IW-1:0] i_q, i_d, k_q, k_d, lag_q, lag_d;
    logic [PW-1:0] acc_q, acc_d, peak_q, peak_d;

    logic [N-1:0]  win;
    logic          win_full;
    logic          arm, rearm;
    logic [IW-1:0] ref_idx;
    logic          match;
    logic [PW-1:0] score;

    assign arm   = (state_q == ST_IDLE) && (start || auto);
    assign rearm = (state_q == ST_REPORT) && res_ready && auto;

    corr_window_buf #(
        .N     (N),
        .DECIM (DECIM)
    ) u_win (
        .clk  (clk),
        .rst  (rst),
        .clr  (arm || rearm),
        .en   (state_q == ST_CAPTURE),
        .sig  (sig),
        .w    (win),
        .full (win_full)
    );

    // N is a power of two, so wrap-around of the index width is the circular shift.
    assign ref_idx = i_q + k_q;
    assign match   = (win[i_q] == ref_q[ref_idx]);
    assign score   = acc_q + PW'(match);

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        i_d     = i_q;
        k_d     = k_q;
        acc_d   = acc_q;
        peak_d  = peak_q;
        lag_d   = lag_q;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_CAPTURE;
                    ref_d   = ref_code;
                    peak_d  = '0;
                    lag_d   = '0;
                end
            end
            ST_CAPTURE: begin
                if (win_full) begin
                    state_d = ST_CORR;
                    i_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            ST_CORR: begin
                i_d = i_q + 1'b1;
                if (i_q == IW'(N - 1)) begin
                    acc_d = '0;
                    k_d   = k_q + 1'b1;
                    if ((score > peak_q) || (k_q == '0)) begin
                        peak_d = score;
                        lag_d  = k_q;
                    end
                    if (k_q == IW'(LAGS - 1)) begin
                        state_d = ST_REPORT;
                    end
                end else begin
                    acc_d = score;
                end
            end
            ST_REPORT: begin
                if (res_ready) begin
                    if (auto) begin
                        state_d = ST_CAPTURE;
                        peak_d  = '0;
                        lag_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ref_q   <= '0;
            i_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            peak_q  <= '0;
            lag_q   <= '0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            i_q     <= i_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            peak_q  <= peak_d;
            lag_q   <= lag_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_REPORT);
    assign res_peak  = peak_q;
    assign res_lag   = lag_q;

endmodule

// File: tb/tb_corr_sequencer.sv
// Bench for corr_sequencer: unit 0 at DECIM=1, unit 1 at DECIM=4, checked against a window/score model.
module tb_corr_sequencer;

    localparam int N = 32;
    localparam int L = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        st [2];
    logic        au [2];
    logic        rd [2];
    logic        sg [2];
    logic [31:0] rf [2];
    logic        bz [2];
    logic        vl [2];
    logic [5:0]  pk [2];
    logic [4:0]  lg [2];

    corr_sequencer #(.N(32), .LAGS(32), .DECIM(1)) dut0 (
        .clk(clk), .rst(rst), .sig(sg[0]), .start(st[0]), .auto(au[0]),
        .ref_code(rf[0]), .busy(bz[0]), .res_valid(vl[0]), .res_ready(rd[0]),
        .res_peak(pk[0]), .res_lag(lg[0])
    );

    corr_sequencer #(.N(32), .LAGS(32), .DECIM(4)) dut4 (
        .clk(clk), .rst(rst), .sig(sg[1]), .start(st[1]), .auto(au[1]),
        .ref_code(rf[1]), .busy(bz[1]), .res_valid(vl[1]), .res_ready(rd[1]),
        .res_peak(pk[1]), .res_lag(lg[1])
    );

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    bit          chk_en = 1'b0;

    // Model state: a run is "armed at cycle m_t"; everything else follows from elapsed cycles.
    int          D [2] = '{1, 4};
    bit          m_run [2];
    bit          m_valid [2];
    bit          m_busy [2];
    int unsigned m_t [2];
    int          m_peak [2];
    int          m_lag [2];
    logic [31:0] m_ref [2];
    logic [31:0] m_w [2];
    int unsigned mc, mr;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic score(input logic [31:0] w, input logic [31:0] rv, output int bp, output int bl);
        int s;
        bp = 0;
        bl = 0;
        for (int k = 0; k < L; k++) begin
            s = 0;
            for (int i = 0; i < N; i++) if (w[i] == rv[(i + k) % N]) s++;
            if (k == 0 || s > bp) begin
                bp = s;
                bl = k;
            end
        end
    endtask

    task automatic arm(input int u, input int unsigned c);
        m_run[u]  = 1'b1;
        m_busy[u] = 1'b1;
        m_t[u]    = c;
        m_peak[u] = 0;
        m_lag[u]  = 0;
        m_w[u]    = '0;
    endtask

    always @(posedge clk) begin
        mc = cyc;
        cyc++;
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                m_run[u] = 1'b0; m_valid[u] = 1'b0; m_busy[u] = 1'b0;
                m_peak[u] = 0; m_lag[u] = 0;
            end else if (!m_run[u]) begin
                if (st[u] || au[u]) begin
                    m_ref[u] = rf[u];
                    arm(u, mc);
                end
            end else if (m_valid[u]) begin
                if (rd[u]) begin
                    m_valid[u] = 1'b0;
                    if (au[u]) arm(u, mc);
                    else begin
                        m_run[u] = 1'b0;
                        m_busy[u] = 1'b0;
                    end
                end
            end else begin
                mr = mc - m_t[u];
                if (mr >= 1 && mr <= N * D[u] && ((mr - 1) % D[u]) == 0)
                    m_w[u][(mr - 1) / D[u]] = sg[u];
                if (mr == N * D[u] + N * L) begin
                    score(m_w[u], m_ref[u], m_peak[u], m_lag[u]);
                    m_valid[u] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                check($sformatf("u%0d busy", u), 32'(bz[u]), 32'(m_busy[u]));
                check($sformatf("u%0d valid", u), 32'(vl[u]), 32'(m_valid[u]));
                if (!m_run[u] || m_valid[u]) begin
                    check($sformatf("u%0d peak", u), 32'(pk[u]), m_peak[u]);
                    check($sformatf("u%0d lag", u), 32'(lg[u]), m_lag[u]);
                end
            end
        end
    end

    task automatic start_run(input int u, input logic [31:0] refv, input logic sigv, output int unsigned t0);
        rf[u] = refv;
        sg[u] = sigv;
        st[u] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        st[u] = 1'b0;
    endtask

    // mode 0: sig held; mode 1: sig high only in cycle 6; mode 2: sig high when (cycle % 4) == 1
    task automatic wait_valid(input int u, input int mode, input int unsigned t0, output int lat);
        lat = -1;
        for (int n = 0; n < 4000; n++) begin
            if (vl[u] === 1'b1) begin
                lat = int'(cyc - t0);
                break;
            end
            if (mode == 1) sg[u] = ((cyc - t0) == 6);
            if (mode == 2) sg[u] = (((cyc - t0) % 4) == 1);
            @(negedge clk);
        end
    endtask

    int unsigned t0, prev;
    int lat;

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            st[u] = 1'b0; au[u] = 1'b0; rd[u] = 1'b1; sg[u] = 1'b0; rf[u] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset busy", 32'(bz[0]), 0);
        check("reset valid", 32'(vl[0]), 0);
        check("reset peak", 32'(pk[0]), 0);
        check("reset lag", 32'(lg[0]), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // all-ones match
        start_run(0, 32'hFFFF_FFFF, 1'b1, t0);
        wait_valid(0, 0, t0, lat);
        check("ones latency", lat, 1057);
        check("ones peak", 32'(pk[0]), 32);
        check("ones lag", 32'(lg[0]), 0);
        @(negedge clk);
        check("ones drop valid", 32'(vl[0]), 0);
        check("ones idle", 32'(bz[0]), 0);

        // single pulse at the 6th sample
        start_run(0, 32'h0000_0001, 1'b0, t0);
        wait_valid(0, 1, t0, lat);
        check("pulse peak", 32'(pk[0]), 32);
        check("pulse lag", 32'(lg[0]), 27);
        sg[0] = 1'b0;
        @(negedge clk);

        // tie across all lags
        start_run(0, 32'h0, 1'b0, t0);
        wait_valid(0, 0, t0, lat);
        check("tie peak", 32'(pk[0]), 32);
        check("tie lag", 32'(lg[0]), 0);
        @(negedge clk);

        // backpressure with ignored start and ref_code change
        rd[0] = 1'b0;
        start_run(0, 32'hFFFF_FFFF, 1'b1, t0);
        wait_valid(0, 0, t0, lat);
        check("bp latency", lat, 1057);
        for (int n = 0; n < 100; n++) begin
            st[0] = (n == 10);
            if (n == 20) rf[0] = 32'h1234_5678;
            @(negedge clk);
            check("bp valid held", 32'(vl[0]), 1);
            check("bp peak held", 32'(pk[0]), 32);
            check("bp lag held", 32'(lg[0]), 0);
        end
        rd[0] = 1'b1;
        @(negedge clk);
        check("bp accept idle", 32'(bz[0]), 0);
        check("bp accept valid", 32'(vl[0]), 0);
        repeat (3) @(negedge clk);
        check("bp no recapture", 32'(bz[0]), 0);

        // reset mid-CORR
        start_run(0, 32'hFFFF_FFFF, 1'b1, t0);
        for (int n = 0; n < 600 && (cyc - t0) < 500; n++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst busy", 32'(bz[0]), 0);
        check("rst valid", 32'(vl[0]), 0);
        check("rst peak", 32'(pk[0]), 0);
        check("rst lag", 32'(lg[0]), 0);
        start_run(0, 32'hFFFF_FFFF, 1'b1, t0);
        wait_valid(0, 0, t0, lat);
        check("rerun latency", lat, 1057);
        check("rerun peak", 32'(pk[0]), 32);
        @(negedge clk);

        // auto mode on the DECIM=4 unit
        rf[1] = 32'hFFFF_FFFF;
        sg[1] = 1'b0;
        au[1] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        wait_valid(1, 2, t0, lat);
        check("auto first latency", lat, 1153);
        check("auto decimated peak", 32'(pk[1]), 32);
        check("auto decimated lag", 32'(lg[1]), 0);
        for (int r = 0; r < 2; r++) begin
            prev = cyc;
            @(negedge clk);
            check("auto rearm busy", 32'(bz[1]), 1);
            wait_valid(1, 2, t0, lat);
            check("auto interval", int'(cyc - prev), 1153);
        end
        au[1] = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 1400 && bz[1] !== 1'b0; n++) @(negedge clk);
        check("auto stops", 32'(bz[1]), 0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
